// File: rtl/rs_bank_pkg.sv
// Shared types and sizing for the reservation-station bank and the issue scheduler.
package rs_bank_pkg;

  localparam int unsigned NUM_RS   = 4;
  localparam int unsigned RS_IDX_W = 2;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned DATA_W   = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  rob;
    logic [2:0]        alu_op;
    logic [1:0]        branch_type;
    logic              busy;
  } rs_data_t;

  typedef struct packed {
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [2:0]        alu_op;
    logic [1:0]        branch_type;
    logic [TAG_W-1:0]  rob;
  } rs_issue_t;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the station entries and oldest-ready one-hot selection.
module rs_age_select
  import rs_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_RS-1:0]   i_ready,
  input  logic                i_alloc_en,
  input  logic [RS_IDX_W-1:0] i_alloc_idx,
  input  logic [NUM_RS-1:0]   i_dispatch,
  input  logic                i_flush,
  output logic [NUM_RS-1:0]   o_sel
);

  // r_older[i][j] = 1 : entry i is older than entry j (meaningful only when both busy)
  logic [NUM_RS-1:0] r_older [NUM_RS];
  logic [NUM_RS-1:0] w_blocked;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      for (int unsigned i = 0; i < NUM_RS; i++) r_older[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        if (i_dispatch[i]) r_older[i] <= '0;
      end
      // Allocation is applied after dispatch so a freed row picks up the new column bit.
      if (i_alloc_en) begin
        for (int unsigned i = 0; i < NUM_RS; i++) begin
          if (RS_IDX_W'(i) == i_alloc_idx) r_older[i] <= '0;
          else                             r_older[i][i_alloc_idx] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_blocked = '0;
    o_sel     = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      for (int unsigned j = 0; j < NUM_RS; j++) begin
        if (j != i && i_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
      o_sel[i] = i_ready[i] & ~w_blocked[i];
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: CDB wakeup, oldest-ready selection and a valid/ready issue register.
module rs_bank
  import rs_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_en,
  input  logic [RS_IDX_W-1:0] alloc_idx,
  input  rs_data_t            alloc_pkt,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DATA_W-1:0]   cdb_value,
  input  logic                flush,
  output logic [NUM_RS-1:0]   busy_bus,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [DATA_W-1:0]   issue_vj,
  output logic [DATA_W-1:0]   issue_vk,
  output logic [2:0]          issue_alu_op,
  output logic [1:0]          issue_branch_type,
  output logic [TAG_W-1:0]    issue_rob
);

  rs_data_t          r_ent [NUM_RS];
  rs_issue_t         r_issue;
  logic              r_issue_valid;

  rs_data_t          w_alloc_ent;
  rs_issue_t         w_sel_issue;
  logic [NUM_RS-1:0] w_ready;
  logic [NUM_RS-1:0] w_busy;
  logic [NUM_RS-1:0] w_sel;
  logic [NUM_RS-1:0] w_disp_vec;
  logic              w_alloc_ok;
  logic              w_dispatch;
  logic              w_cdb_hit;

  assign w_cdb_hit  = cdb_valid && (cdb_tag != '0);
  assign w_alloc_ok = alloc_en && !w_busy[alloc_idx] && !flush;
  assign w_dispatch = (|w_sel) && (!r_issue_valid || issue_ready);
  assign w_disp_vec = w_sel & {NUM_RS{w_dispatch}};

  always_comb begin
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && (r_ent[i].qj == '0) && (r_ent[i].qk == '0);
    end
  end

  // Same-cycle CDB bypass into the packet being written.
  always_comb begin
    w_alloc_ent      = alloc_pkt;
    w_alloc_ent.busy = 1'b1;
    if (w_cdb_hit && alloc_pkt.qj == cdb_tag) begin
      w_alloc_ent.vj = cdb_value;
      w_alloc_ent.qj = '0;
    end
    if (w_cdb_hit && alloc_pkt.qk == cdb_tag) begin
      w_alloc_ent.vk = cdb_value;
      w_alloc_ent.qk = '0;
    end
  end

  always_comb begin
    w_sel_issue = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (w_sel[i]) begin
        w_sel_issue.vj          = r_ent[i].vj;
        w_sel_issue.vk          = r_ent[i].vk;
        w_sel_issue.alu_op      = r_ent[i].alu_op;
        w_sel_issue.branch_type = r_ent[i].branch_type;
        w_sel_issue.rob         = r_ent[i].rob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RS; i++) r_ent[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_RS; i++) r_ent[i].busy <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        if (r_ent[i].busy && w_cdb_hit && r_ent[i].qj == cdb_tag) begin
          r_ent[i].vj <= cdb_value;
          r_ent[i].qj <= '0;
        end
        if (r_ent[i].busy && w_cdb_hit && r_ent[i].qk == cdb_tag) begin
          r_ent[i].vk <= cdb_value;
          r_ent[i].qk <= '0;
        end
        if (w_disp_vec[i]) r_ent[i].busy <= 1'b0;
        if (w_alloc_ok && RS_IDX_W'(i) == alloc_idx) r_ent[i] <= w_alloc_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issue       <= '0;
      r_issue_valid <= 1'b0;
    end else if (flush) begin
      r_issue_valid <= 1'b0;
    end else if (w_dispatch) begin
      r_issue       <= w_sel_issue;
      r_issue_valid <= 1'b1;
    end else if (issue_ready) begin
      r_issue_valid <= 1'b0;
    end
  end

  rs_age_select u_age (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ready     (w_ready),
    .i_alloc_en  (w_alloc_ok),
    .i_alloc_idx (alloc_idx),
    .i_dispatch  (w_disp_vec),
    .i_flush     (flush),
    .o_sel       (w_sel)
  );

  assign busy_bus          = w_busy;
  assign issue_valid       = r_issue_valid;
  assign issue_vj          = r_issue.vj;
  assign issue_vk          = r_issue.vk;
  assign issue_alu_op      = r_issue.alu_op;
  assign issue_branch_type = r_issue.branch_type;
  assign issue_rob         = r_issue.rob;

  a_alloc_free: assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_en && !flush) |-> !w_busy[alloc_idx]);

endmodule

// File: tb/tb_rs_bank.sv
// Directed self-checking bench for rs_bank.
module tb_rs_bank;
  import rs_bank_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                alloc_en;
  logic [RS_IDX_W-1:0] alloc_idx;
  rs_data_t            alloc_pkt;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_value;
  logic                flush;
  logic [NUM_RS-1:0]   busy_bus;
  logic                issue_valid;
  logic                issue_ready;
  logic [DATA_W-1:0]   issue_vj;
  logic [DATA_W-1:0]   issue_vk;
  logic [2:0]          issue_alu_op;
  logic [1:0]          issue_branch_type;
  logic [TAG_W-1:0]    issue_rob;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rs_bank dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alloc_en          (alloc_en),
    .alloc_idx         (alloc_idx),
    .alloc_pkt         (alloc_pkt),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_value         (cdb_value),
    .flush             (flush),
    .busy_bus          (busy_bus),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_vj          (issue_vj),
    .issue_vk          (issue_vk),
    .issue_alu_op      (issue_alu_op),
    .issue_branch_type (issue_branch_type),
    .issue_rob         (issue_rob)
  );

  function automatic rs_data_t mk(input logic [2:0] qj, input logic [2:0] qk,
                                  input logic [31:0] vj, input logic [31:0] vk,
                                  input logic [2:0] rob, input logic [2:0] op,
                                  input logic [1:0] br);
    rs_data_t p;
    p.qj = qj; p.qk = qk; p.vj = vj; p.vk = vk;
    p.rob = rob; p.alu_op = op; p.branch_type = br; p.busy = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en  = 1'b0;
    alloc_idx = '0;
    alloc_pkt = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_value = '0;
    flush     = 1'b0;
  endtask

  task automatic do_alloc(input logic [1:0] idx, input rs_data_t p);
    alloc_en  = 1'b1;
    alloc_idx = idx;
    alloc_pkt = p;
  endtask

  task automatic test_reset();
    idle();
    issue_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if ({busy_bus, issue_valid, issue_vj, issue_vk, issue_alu_op, issue_branch_type, issue_rob} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b valid=%b vj=%h vk=%h op=%h br=%h rob=%h, want all zero",
               busy_bus, issue_valid, issue_vj, issue_vk, issue_alu_op, issue_branch_type, issue_rob);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ready_alloc();
    issue_ready = 1'b1;
    do_alloc(2'd0, mk(3'd0, 3'd0, 32'd5, 32'd7, 3'd3, 3'd0, 2'd1));
    tick();
    idle();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL ready_alloc_edge: busy=%b valid=%b, want busy=0001 valid=0", busy_bus, issue_valid);
    end
    tick();
    n_tests++;
    if ({busy_bus, issue_valid, issue_vj, issue_vk, issue_rob, issue_alu_op, issue_branch_type}
        !== {4'b0000, 1'b1, 32'd5, 32'd7, 3'd3, 3'd0, 2'd1}) begin
      n_fail++;
      $display("FAIL ready_alloc_issue: busy=%b valid=%b vj=%h vk=%h rob=%0d op=%0d br=%0d, want 0000 1 5 7 3 0 1",
               busy_bus, issue_valid, issue_vj, issue_vk, issue_rob, issue_alu_op, issue_branch_type);
    end
    tick();
    n_tests++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_alloc_drain: valid=%b, want 0", issue_valid);
    end
  endtask

  task automatic test_wakeup();
    issue_ready = 1'b1;
    do_alloc(2'd1, mk(3'd4, 3'd0, 32'd0, 32'd9, 3'd1, 3'd2, 2'd0));
    tick();
    idle();
    tick();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL wakeup_wait: busy=%b valid=%b, want busy=0010 valid=0", busy_bus, issue_valid);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 32'h20;
    tick();
    idle();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL wakeup_no_cdb_path: busy=%b valid=%b, want busy=0010 valid=0", busy_bus, issue_valid);
    end
    tick();
    n_tests++;
    if ({issue_valid, issue_vj, issue_vk, issue_rob, busy_bus} !== {1'b1, 32'h20, 32'd9, 3'd1, 4'b0000}) begin
      n_fail++;
      $display("FAIL wakeup_issue: valid=%b vj=%h vk=%h rob=%0d busy=%b, want 1 20 9 1 0000",
               issue_valid, issue_vj, issue_vk, issue_rob, busy_bus);
    end
    tick();
  endtask

  task automatic test_bypass();
    issue_ready = 1'b1;
    do_alloc(2'd2, mk(3'd0, 3'd5, 32'd1, 32'd0, 3'd2, 3'd3, 2'd0));
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_value = 32'hAB;
    tick();
    idle();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0100, 1'b0}) begin
      n_fail++;
      $display("FAIL bypass_alloc: busy=%b valid=%b, want busy=0100 valid=0", busy_bus, issue_valid);
    end
    tick();
    n_tests++;
    if ({issue_valid, issue_vj, issue_vk, issue_rob, issue_alu_op} !== {1'b1, 32'd1, 32'hAB, 3'd2, 3'd3}) begin
      n_fail++;
      $display("FAIL bypass_issue: valid=%b vj=%h vk=%h rob=%0d op=%0d, want 1 1 ab 2 3",
               issue_valid, issue_vj, issue_vk, issue_rob, issue_alu_op);
    end
    tick();
  endtask

  task automatic test_age_order();
    issue_ready = 1'b1;
    do_alloc(2'd2, mk(3'd6, 3'd0, 32'd0, 32'h22, 3'd4, 3'd1, 2'd0));
    tick();
    do_alloc(2'd0, mk(3'd6, 3'd0, 32'd0, 32'h11, 3'd5, 3'd2, 2'd0));
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_value = 32'h66;
    tick();
    idle();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0101, 1'b0}) begin
      n_fail++;
      $display("FAIL age_woken: busy=%b valid=%b, want busy=0101 valid=0", busy_bus, issue_valid);
    end
    tick();
    n_tests++;
    if ({issue_valid, issue_rob, issue_vj, issue_vk, issue_alu_op, busy_bus}
        !== {1'b1, 3'd4, 32'h66, 32'h22, 3'd1, 4'b0001}) begin
      n_fail++;
      $display("FAIL age_first: valid=%b rob=%0d vj=%h vk=%h op=%0d busy=%b, want 1 4 66 22 1 0001",
               issue_valid, issue_rob, issue_vj, issue_vk, issue_alu_op, busy_bus);
    end
    tick();
    n_tests++;
    if ({issue_valid, issue_rob, issue_vj, issue_vk, issue_alu_op, busy_bus}
        !== {1'b1, 3'd5, 32'h66, 32'h11, 3'd2, 4'b0000}) begin
      n_fail++;
      $display("FAIL age_second: valid=%b rob=%0d vj=%h vk=%h op=%0d busy=%b, want 1 5 66 11 2 0000",
               issue_valid, issue_rob, issue_vj, issue_vk, issue_alu_op, busy_bus);
    end
    tick();
  endtask

  task automatic test_backpressure();
    issue_ready = 1'b0;
    do_alloc(2'd1, mk(3'd0, 3'd0, 32'h10, 32'h1, 3'd6, 3'd4, 2'd2));
    tick();
    do_alloc(2'd3, mk(3'd0, 3'd0, 32'h30, 32'h3, 3'd7, 3'd5, 2'd3));
    tick();
    idle();
    n_tests++;
    if ({issue_valid, issue_rob, busy_bus} !== {1'b1, 3'd6, 4'b1000}) begin
      n_fail++;
      $display("FAIL bp_alloc_and_dispatch: valid=%b rob=%0d busy=%b, want 1 6 1000",
               issue_valid, issue_rob, busy_bus);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if ({issue_valid, issue_rob, issue_vj, issue_vk, issue_alu_op, issue_branch_type, busy_bus}
          !== {1'b1, 3'd6, 32'h10, 32'h1, 3'd4, 2'd2, 4'b1000}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b rob=%0d vj=%h vk=%h op=%0d br=%0d busy=%b, want 1 6 10 1 4 2 1000",
                 k, issue_valid, issue_rob, issue_vj, issue_vk, issue_alu_op, issue_branch_type, busy_bus);
      end
    end
    issue_ready = 1'b1;
    tick();
    n_tests++;
    if ({issue_valid, issue_rob, issue_vj, issue_branch_type, busy_bus} !== {1'b1, 3'd7, 32'h30, 2'd3, 4'b0000}) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b rob=%0d vj=%h br=%0d busy=%b, want 1 7 30 3 0000",
               issue_valid, issue_rob, issue_vj, issue_branch_type, busy_bus);
    end
    tick();
    n_tests++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b, want 0", issue_valid);
    end
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    do_alloc(2'd0, mk(3'd0, 3'd0, 32'h1, 32'h2, 3'd1, 3'd0, 2'd0));
    tick();
    do_alloc(2'd1, mk(3'd7, 3'd0, 32'h0, 32'h0, 3'd2, 3'd0, 2'd0));
    tick();
    do_alloc(2'd2, mk(3'd7, 3'd0, 32'h0, 32'h0, 3'd3, 3'd0, 2'd0));
    tick();
    do_alloc(2'd3, mk(3'd7, 3'd0, 32'h0, 32'h0, 3'd4, 3'd0, 2'd0));
    tick();
    n_tests++;
    if ({busy_bus, issue_valid, issue_rob} !== {4'b1110, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL flush_setup: busy=%b valid=%b rob=%0d, want 1110 1 1", busy_bus, issue_valid, issue_rob);
    end
    do_alloc(2'd0, mk(3'd0, 3'd0, 32'h5, 32'h5, 3'd5, 3'd0, 2'd0));
    flush = 1'b1;
    tick();
    idle();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_clear: busy=%b valid=%b, want busy=0000 valid=0", busy_bus, issue_valid);
    end
    issue_ready = 1'b1;
    tick(); tick();
    n_tests++;
    if ({busy_bus, issue_valid} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_alloc_dropped: busy=%b valid=%b, want busy=0000 valid=0", busy_bus, issue_valid);
    end
  endtask

  task automatic test_reset_mid();
    issue_ready = 1'b0;
    do_alloc(2'd3, mk(3'd0, 3'd0, 32'hDEAD, 32'hBEEF, 3'd6, 3'd7, 2'd3));
    tick();
    do_alloc(2'd2, mk(3'd1, 3'd0, 32'h0, 32'h0, 3'd2, 3'd0, 2'd0));
    tick();
    idle();
    n_tests++;
    if ({busy_bus, issue_valid, issue_vj} !== {4'b0100, 1'b1, 32'hDEAD}) begin
      n_fail++;
      $display("FAIL reset_mid_setup: busy=%b valid=%b vj=%h, want 0100 1 dead", busy_bus, issue_valid, issue_vj);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if ({busy_bus, issue_valid, issue_vj, issue_vk, issue_alu_op, issue_branch_type, issue_rob} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b valid=%b vj=%h vk=%h op=%h br=%h rob=%h, want all zero",
               busy_bus, issue_valid, issue_vj, issue_vk, issue_alu_op, issue_branch_type, issue_rob);
    end
    tick();
  endtask

  initial begin
    idle();
    rst_n       = 1'b0;
    issue_ready = 1'b1;
    test_reset();
    test_ready_alloc();
    test_wakeup();
    test_bypass();
    test_age_order();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
